// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: Diff = X - Y - Bin, one bit per cycle, LSB first.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             Ovf,
`endif
  output logic             Zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-subtractor cell: difference bit and borrow-out.
  function automatic logic diff_bit(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic c);
    return (~a & b) | (~a & c) | (b & c);
  endfunction

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] sh_x_r, sh_x_next_s;
  logic [WIDTH-1:0] sh_y_r, sh_y_next_s;
  logic [WIDTH-1:0] sh_d_r, sh_d_next_s;
  logic             borrow_r, borrow_next_s;
  logic [CW-1:0]    cnt_r, cnt_next_s;
  logic             load_result_s;
  logic             d_s;
  logic             borrow_upd_s;
  logic             busy_r, done_r, bout_r, zero_r;
  logic [WIDTH-1:0] diff_r;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             xs_r, ys_r, ovf_r;
`endif

  // Next-state and datapath decode for the three-state sequencer.
  always_comb begin
    state_next_s  = state_r;
    sh_x_next_s   = sh_x_r;
    sh_y_next_s   = sh_y_r;
    sh_d_next_s   = sh_d_r;
    borrow_next_s = borrow_r;
    cnt_next_s    = cnt_r;
    load_result_s = 1'b0;
    d_s           = diff_bit(sh_x_r[0], sh_y_r[0], borrow_r);
    borrow_upd_s  = borrow_bit(sh_x_r[0], sh_y_r[0], borrow_r);
    case (state_r)
      IDLE: begin
        if (Start) begin
          sh_x_next_s   = X;
          sh_y_next_s   = Y;
          borrow_next_s = Bin;
          cnt_next_s    = '0;
          state_next_s  = RUN;
        end else begin
          state_next_s  = IDLE;
        end
      end
      RUN: begin
        sh_x_next_s   = {1'b0, sh_x_r[WIDTH-1:1]};
        sh_y_next_s   = {1'b0, sh_y_r[WIDTH-1:1]};
        sh_d_next_s   = {d_s, sh_d_r[WIDTH-1:1]};
        borrow_next_s = borrow_upd_s;
        cnt_next_s    = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_next_s  = DONE;
          load_result_s = 1'b1;
        end else begin
          state_next_s  = RUN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Sequencer state, shift registers, counter and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      sh_x_r   <= '0;
      sh_y_r   <= '0;
      sh_d_r   <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      sh_x_r   <= sh_x_next_s;
      sh_y_r   <= sh_y_next_s;
      sh_d_r   <= sh_d_next_s;
      borrow_r <= borrow_next_s;
      cnt_r    <= cnt_next_s;
      busy_r   <= (state_next_s != IDLE);
      done_r   <= (state_next_s == DONE);
    end
  end

  // Result registers only move on the last RUN edge, so they hold across IDLE and the next RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_r <= '0;
      bout_r <= 1'b0;
      zero_r <= 1'b1;
    end else if (load_result_s) begin
      diff_r <= sh_d_next_s;
      bout_r <= borrow_next_s;
      zero_r <= ~|sh_d_next_s;
    end else begin
      diff_r <= diff_r;
      bout_r <= bout_r;
      zero_r <= zero_r;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits are kept aside because the shifters lose them during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      xs_r  <= 1'b0;
      ys_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else if ((state_r == IDLE) && Start) begin
      xs_r  <= X[WIDTH-1];
      ys_r  <= Y[WIDTH-1];
      ovf_r <= ovf_r;
    end else if (load_result_s) begin
      xs_r  <= xs_r;
      ys_r  <= ys_r;
      ovf_r <= (xs_r != ys_r) & (sh_d_next_s[WIDTH-1] != xs_r);
    end else begin
      xs_r  <= xs_r;
      ys_r  <= ys_r;
      ovf_r <= ovf_r;
    end
  end

  assign Ovf = ovf_r;
`endif

  assign Busy = busy_r;
  assign Done = done_r;
  assign Diff = diff_r;
  assign Bout = bout_r;
  assign Zero = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] X = 8'h00;
  logic [7:0] Y = 8'h00;
  logic       Bin = 1'b0;
  logic       Busy, Done, Bout, Zero;
  logic [7:0] Diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       Ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .Start(Start), .X(X), .Y(Y), .Bin(Bin),
    .Busy(Busy), .Done(Done), .Diff(Diff), .Bout(Bout),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .Ovf(Ovf),
`endif
    .Zero(Zero)
  );

  always #5 clk = ~clk;

  // Drive Start for one cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic b);
    Start = 1'b1; X = x; Y = y; Bin = b;
    @(negedge clk);
    Start = 1'b0; X = 8'h00; Y = 8'h00; Bin = 1'b0;
  endtask

  // Wait (bounded) for Done; cyc = cycle index of the pulse or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (Done === 1'b1) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", Done); end
    n_cmp++; if (Diff !== 8'h00) begin n_err++; $display("FAIL reset_diff: got %h want 00", Diff); end
    n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL reset_bout: got %b want 0", Bout); end
    n_cmp++; if (Zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", Zero); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    n_cmp++; if (Ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", Ovf); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    start_op(8'd5, 8'd3, 1'b0);
    n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_run: got %b want 1", Busy); end
    wait_done(cyc);
    n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL basic_latency: got %0d want 9", cyc); end
    n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_done: got %b want 1", Busy); end
    n_cmp++; if (Diff !== 8'h02) begin n_err++; $display("FAIL basic_diff: got %h want 02", Diff); end
    n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL basic_bout: got %b want 0", Bout); end
    n_cmp++; if (Zero !== 1'b0) begin n_err++; $display("FAIL basic_zero: got %b want 0", Zero); end
    // Start raised during DONE must be ignored
    Start = 1'b1; X = 8'hFF; Y = 8'h00;
    @(negedge clk);
    Start = 1'b0;
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", Done); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b want 0", Busy); end
    @(negedge clk);
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL done_start_ignored: busy got %b want 0", Busy); end
  endtask

  task automatic test_borrow();
    int cyc;
    start_op(8'd3, 8'd5, 1'b0);
    wait_done(cyc);
    n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL borrow_latency: got %0d want 9", cyc); end
    n_cmp++; if (Diff !== 8'hFE) begin n_err++; $display("FAIL borrow_diff: got %h want fe", Diff); end
    n_cmp++; if (Bout !== 1'b1) begin n_err++; $display("FAIL borrow_bout: got %b want 1", Bout); end
    n_cmp++; if (Zero !== 1'b0) begin n_err++; $display("FAIL borrow_zero: got %b want 0", Zero); end
    @(negedge clk);
    start_op(8'd0, 8'd0, 1'b1);
    n_cmp++; if (Diff !== 8'hFE) begin n_err++; $display("FAIL hold_in_run: got %h want fe", Diff); end
    wait_done(cyc);
    n_cmp++; if (Diff !== 8'hFF) begin n_err++; $display("FAIL bin_diff: got %h want ff", Diff); end
    n_cmp++; if (Bout !== 1'b1) begin n_err++; $display("FAIL bin_bout: got %b want 1", Bout); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int cyc;
    start_op(8'h2A, 8'h2A, 1'b0);
    wait_done(cyc);
    n_cmp++; if (Diff !== 8'h00) begin n_err++; $display("FAIL zero_diff: got %h want 00", Diff); end
    n_cmp++; if (Zero !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %b want 1", Zero); end
    n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL zero_bout: got %b want 0", Bout); end
    X = 8'h55; Y = 8'h11;
    repeat (3) @(negedge clk);
    n_cmp++; if (Diff !== 8'h00) begin n_err++; $display("FAIL zero_hold_diff: got %h want 00", Diff); end
    n_cmp++; if (Zero !== 1'b1) begin n_err++; $display("FAIL zero_hold_flag: got %b want 1", Zero); end
    X = 8'h00; Y = 8'h00;
  endtask

  task automatic test_start_in_run();
    int done_cnt = 0;
    int done_cyc = -1;
    start_op(8'd9, 8'd4, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      n_cmp++;
      if (Busy !== (c <= 9)) begin
        n_err++; $display("FAIL run_busy_c%0d: got %b want %b", c, Busy, (c <= 9));
      end
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 3) begin
        Start = 1'b1; X = 8'd1; Y = 8'd1;
      end else if (c == 4) begin
        Start = 1'b0; X = 8'd0; Y = 8'd0;
      end
      @(negedge clk);
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL run_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc != 9) begin n_err++; $display("FAIL run_done_cycle: got %0d want 9", done_cyc); end
    n_cmp++; if (Diff !== 8'h05) begin n_err++; $display("FAIL run_diff: got %h want 05", Diff); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int done_cnt = 0;
    start_op(8'd9, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", Busy); end
    n_cmp++; if (Diff !== 8'h00) begin n_err++; $display("FAIL rstmid_diff: got %h want 00", Diff); end
    n_cmp++; if (Zero !== 1'b1) begin n_err++; $display("FAIL rstmid_zero: got %b want 1", Zero); end
    for (int c = 0; c < 10; c++) begin
      if (Done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt); end
    start_op(8'd7, 8'd2, 1'b1);
    wait_done(cyc);
    n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL rstmid_fresh_latency: got %0d want 9", cyc); end
    n_cmp++; if (Diff !== 8'h04) begin n_err++; $display("FAIL rstmid_fresh_diff: got %h want 04", Diff); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(8'd5, 8'd3, 1'b0);
    wait_done(cyc);
    @(negedge clk);
    start_op(8'h10, 8'h01, 1'b0);
    wait_done(cyc);
    n_cmp++; if (cyc != 9) begin n_err++; $display("FAIL b2b_latency: got %0d want 9", cyc); end
    n_cmp++; if (Diff !== 8'h0F) begin n_err++; $display("FAIL b2b_diff: got %h want 0f", Diff); end
    n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL b2b_bout: got %b want 0", Bout); end
    @(negedge clk);
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf();
    int cyc;
    start_op(8'h80, 8'h01, 1'b0);
    wait_done(cyc);
    n_cmp++; if (Diff !== 8'h7F) begin n_err++; $display("FAIL ovf1_diff: got %h want 7f", Diff); end
    n_cmp++; if (Ovf !== 1'b1) begin n_err++; $display("FAIL ovf1_ovf: got %b want 1", Ovf); end
    n_cmp++; if (Bout !== 1'b0) begin n_err++; $display("FAIL ovf1_bout: got %b want 0", Bout); end
    @(negedge clk);
    start_op(8'h7F, 8'hFF, 1'b0);
    wait_done(cyc);
    n_cmp++; if (Diff !== 8'h80) begin n_err++; $display("FAIL ovf2_diff: got %h want 80", Diff); end
    n_cmp++; if (Ovf !== 1'b1) begin n_err++; $display("FAIL ovf2_ovf: got %b want 1", Ovf); end
    n_cmp++; if (Bout !== 1'b1) begin n_err++; $display("FAIL ovf2_bout: got %b want 1", Bout); end
    @(negedge clk);
    start_op(8'd5, 8'd3, 1'b0);
    wait_done(cyc);
    n_cmp++; if (Ovf !== 1'b0) begin n_err++; $display("FAIL ovf3_ovf: got %b want 0", Ovf); end
    @(negedge clk);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_borrow();
    test_zero();
    test_start_in_run();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: computes Diff = X - Y - Bin over WIDTH cycles, one bit per cycle, LSB first.
- Counterpart to the combinational full adder: same per-bit cell, inverted for borrow, iterated in time rather than replicated in space.
- Sits in the datapath where area matters more than latency.
- Start/busy/done handshake; result is held until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- Start  input  1  request; sampled only in IDLE
- X  input  WIDTH  minuend; captured on the accepted Start edge
- Y  input  WIDTH  subtrahend; captured on the accepted Start edge
- Bin  input  1  borrow-in; captured on the accepted Start edge
- Busy  output  1  high in RUN and DONE
- Done  output  1  one-cycle pulse in DONE
- Diff  output  WIDTH  result register
- Bout  output  1  final borrow-out
- Zero  output  1  high when Diff == 0

Behaviour:
- Reset (rst high at an edge, any state):
  - state goes to IDLE;
  - Busy, Done, Bout and Diff all go to 0;
  - Zero goes to 1;
  - shift registers and counter are cleared.
- Reset has priority over every other event. A reset during RUN abandons the operation: no Done pulse, and Diff stays 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with Start=1: load shX<=X, shY<=Y, borrow<=Bin, cnt<=0; go to RUN.
  - Start=0: stay.
- RUN, at each edge:
  - a=shX[0], b=shY[0];
  - d = a ^ b ^ borrow;
  - borrow <= (~a & b) | (~a & borrow) | (b & borrow);
  - shX and shY shift right one bit;
  - d enters the MSB of shD, which shifts right;
  - cnt <= cnt+1.
- RUN exit: on the edge where cnt == WIDTH-1 (the last bit processed), go to DONE. On that same edge:
  - Diff <= final shD, including this bit;
  - Bout <= the updated borrow;
  - Zero <= (final shD == 0).
- DONE:
  - lasts exactly one cycle with Done=1, Busy=1;
  - the next edge returns to IDLE unconditionally;
  - Start in DONE is ignored.
- Latency: Start high in cycle 0 gives RUN in cycles 1..WIDTH and Done=1 in cycle WIDTH+1. Back-to-back operations need Start in cycle WIDTH+2 or later.
- Start during RUN or DONE: ignored. X, Y and Bin changes while busy have no effect.
- Diff, Bout and Zero change only on a RUN->DONE edge or on reset. They hold their values through IDLE and the next RUN.
- Arithmetic is modulo 2^WIDTH; Bout=1 exactly when X < Y + Bin (unsigned).
- cnt width is clog2(WIDTH); no wrap occurs because the exit happens at WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- When defined:
  - adds output port Ovf (1 bit), reset value 0;
  - on the RUN->DONE edge, Ovf <= (xs != ys) & (ds != xs), where xs, ys and ds are the MSBs of X, Y and the result (two's-complement signed overflow);
  - xs and ys are captured into dedicated flops at Start;
  - Ovf holds like Diff.
- When undefined: the port, the flops and the logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, X=5, Y=3, Bin=0, Start in cycle 0 -> Done only in cycle 9; Diff=0x02, Bout=0, Zero=0.
- X=3, Y=5, Bin=0 -> Diff=0xFE, Bout=1, Zero=0. Then X=0, Y=0, Bin=1 -> Diff=0xFF, Bout=1.
- X=0x2A, Y=0x2A, Bin=0 -> Diff=0x00, Zero=1, Bout=0. Diff holds 0x00 through the following IDLE cycles.
- Start at cycle 0 (X=9, Y=4), Start re-asserted at cycle 3 with X=1, Y=1 -> single Done at cycle 9, Diff=0x05. Busy stays high in cycles 1..9, and there is no second operation.
- Start at cycle 0 (X=9, Y=4), rst=1 in cycle 4 -> from cycle 5: Busy=0, Diff=0, Zero=1, no Done pulse. A fresh start afterwards completes normally.
- With SERIAL_SUBTRACTOR_OVF_EN: X=0x80, Y=0x01 -> Diff=0x7F, Ovf=1, Bout=0. X=0x7F, Y=0xFF -> Diff=0x80, Ovf=1, Bout=1. X=5, Y=3 -> Ovf=0.
